// File: rtl/alu_issue_arbiter_pkg.sv
// Shared constants for the alu issue arbiter: MIPS opcodes/functs the alu decodes and flag bit positions.
package alu_issue_arbiter_pkg;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam int FLG_ZERO = 0;
    localparam int FLG_OVF  = 1;
    localparam int FLG_NEG  = 2;
endpackage

// File: rtl/alu_issue_arbiter_alu.sv
// Combinational MIPS alu: decodes opcode/funct, produces result plus zero/overflow/negative flags.
module alu
    import alu_issue_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] instr,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flags
);
    logic [5:0]        op, fn;
    logic [4:0]        shamt;
    logic [DATA_W-1:0] imm_s, imm_z;
    logic              is_add, is_sub;
    logic              unused_fields;

    assign op    = instr[31:26];
    assign fn    = instr[5:0];
    assign shamt = instr[10:6];
    assign imm_s = {{16{instr[15]}}, instr[15:0]};
    assign imm_z = {16'h0000, instr[15:0]};
    assign unused_fields = ^instr[25:16];

    always_comb begin
        result = '0;
        is_add = 1'b0;
        is_sub = 1'b0;
        case (op)
            OP_RTYPE: case (fn)
                FN_SLL:  result = b << shamt;
                FN_SRL:  result = b >> shamt;
                FN_ADD:  begin result = a + b; is_add = 1'b1; end
                FN_ADDU: result = a + b;
                FN_SUB:  begin result = a - b; is_sub = 1'b1; end
                FN_SUBU: result = a - b;
                FN_AND:  result = a & b;
                FN_OR:   result = a | b;
                FN_XOR:  result = a ^ b;
                FN_NOR:  result = ~(a | b);
                FN_SLT:  result = {31'd0, $signed(a) < $signed(b)};
                FN_SLTU: result = {31'd0, a < b};
                default: result = '0;
            endcase
            // branches compare by subtraction; zero flag drives the decision
            OP_BEQ, OP_BNE: begin result = a - b; is_sub = 1'b1; end
            OP_ADDI: result = a + imm_s;
            OP_ANDI: result = a & imm_z;
            OP_ORI:  result = a | imm_z;
            default: result = '0;
        endcase
    end

    always_comb begin
        flags           = '0;
        flags[FLG_ZERO] = (result == '0);
        flags[FLG_NEG]  = result[DATA_W-1];
        flags[FLG_OVF]  = (is_add & (a[DATA_W-1] == b[DATA_W-1]) & (result[DATA_W-1] != a[DATA_W-1]))
                        | (is_sub & (a[DATA_W-1] != b[DATA_W-1]) & (result[DATA_W-1] != a[DATA_W-1]));
    end
endmodule

// File: rtl/alu_issue_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; FIXED_PRI=1 makes requester 0 always win.
module rr_arb2 #(
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);
    logic rr;
    logic pick0;

    // rr=0 prefers requester 0, rr=1 prefers requester 1
    assign pick0    = FIXED_PRI ? valid[0] : (valid[0] & (~valid[1] | ~rr));
    assign grant[0] = enable & pick0;
    assign grant[1] = enable & valid[1] & ~pick0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr <= 1'b0;
        else if (|grant)
            rr <= grant[0];
    end
endmodule

// File: rtl/alu_issue_arbiter.sv
// Shares one alu between execute (req0) and branch/address unit (req1); result held in a one-entry output register.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter bit FIXED_PRI = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [31:0]       req0_instr,
    input  logic [31:0]       req0_rega,
    input  logic [31:0]       req0_regb,
    input  logic [TAG_W-1:0]  req0_tag,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [31:0]       req1_instr,
    input  logic [31:0]       req1_rega,
    input  logic [31:0]       req1_regb,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              req1_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic [2:0]        out_flags,
    output logic              out_src,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_br_taken
);
    logic                        can_accept;
    logic [1:0]                  grant;
    logic                        sel;
    logic [1:0][DATA_W-1:0]      instr_v, rega_v, regb_v;
    logic [1:0][TAG_W-1:0]       tag_v;
    logic [DATA_W-1:0]           alu_result;
    logic [FLAG_W-1:0]           alu_flags;
    logic [5:0]                  op;
    logic                        br_taken;

    assign can_accept = ~out_valid | out_ready;

    rr_arb2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .valid  ({req1_valid, req0_valid}),
        .enable (can_accept),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel        = grant[1];

    assign instr_v = {req1_instr, req0_instr};
    assign rega_v  = {req1_rega,  req0_rega};
    assign regb_v  = {req1_regb,  req0_regb};
    assign tag_v   = {req1_tag,   req0_tag};

    alu u_alu (
        .instr  (instr_v[sel]),
        .a      (rega_v[sel]),
        .b      (regb_v[sel]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign op       = instr_v[sel][31:26];
    assign br_taken = ((op == OP_BEQ) &  alu_flags[FLG_ZERO])
                    | ((op == OP_BNE) & ~alu_flags[FLG_ZERO]);

    // data fields only move on a grant, so a drain leaves the last entry visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_flags    <= '0;
            out_src      <= 1'b0;
            out_tag      <= '0;
            out_br_taken <= 1'b0;
        end else if (|grant) begin
            out_valid    <= 1'b1;
            out_result   <= alu_result;
            out_flags    <= alu_flags;
            out_src      <= sel;
            out_tag      <= tag_v[sel];
            out_br_taken <= br_taken;
        end else if (out_ready) begin
            out_valid    <= 1'b0;
        end
    end
endmodule
